// File: rtl/bulls_cows_core.sv
// Bulls-and-Cows game engine: N players, D digits, configurable digit base.
// Players enter secrets in turn, then take turns guessing the next player's
// secret. Each guess is validated, then scored one digit per clock. A round
// limit ends the game in a draw.
module bulls_cows_core #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DIGIT_W    = 4,
  parameter int unsigned BASE       = 10,
  parameter int unsigned PLAYERS    = 2,
  parameter int unsigned MAX_ROUNDS = 10,
  localparam int unsigned PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1,
  localparam int unsigned RW = (MAX_ROUNDS > 0) ? $clog2(MAX_ROUNDS + 1) : 1,
  localparam int unsigned CW = $clog2(DIGITS + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      confirma,
  input  logic [DIGITS*DIGIT_W-1:0] SW,
  output logic [2:0]                state,
  output logic [PW-1:0]             player,
  output logic [RW-1:0]             round,
  output logic [CW-1:0]             bulls,
  output logic [CW-1:0]             cows,
  output logic                      result_valid,
  output logic                      err,
  output logic [PW-1:0]             winner
);

  localparam int unsigned SwW = DIGITS * DIGIT_W;
  localparam int unsigned IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW1 = DIGIT_W + 1;

  localparam logic [2:0] StSetup    = 3'd0;
  localparam logic [2:0] StGuess    = 3'd1;
  localparam logic [2:0] StValidate = 3'd2;
  localparam logic [2:0] StScore    = 3'd3;
  localparam logic [2:0] StResult   = 3'd4;
  localparam logic [2:0] StWin      = 3'd5;
  localparam logic [2:0] StDraw     = 3'd6;

  localparam logic [PW-1:0]  LastPlayer = PW'(PLAYERS - 1);
  localparam logic [IW-1:0]  LastIdx    = IW'(DIGITS - 1);
  localparam logic [CW-1:0]  AllBulls   = CW'(DIGITS);
  localparam logic [RW-1:0]  RoundLimit = RW'(MAX_ROUNDS);
  // One extra bit so BASE = 2^DIGIT_W is representable.
  localparam logic [DW1-1:0] BaseLim    = DW1'(BASE);

  // Architectural state
  logic [2:0]     state_q, state_d;
  logic           origin_setup_q, origin_setup_d;  // 1: entry came from SETUP
  logic [PW-1:0]  player_q, player_d;
  logic [RW-1:0]  round_q, round_d;
  logic [CW-1:0]  bulls_q, bulls_d;
  logic [CW-1:0]  cows_q, cows_d;
  logic           rv_q, rv_d;
  logic           err_q, err_d;
  logic [PW-1:0]  winner_q, winner_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [SwW-1:0] entry_q, entry_d;
  logic [SwW-1:0] secret_q [PLAYERS];
  logic [SwW-1:0] secret_d [PLAYERS];
  logic           conf_prev_q;

  // Derived combinational signals
  logic                rise;
  logic [PW-1:0]       opp;
  logic [SwW-1:0]      target;
  logic [DIGIT_W-1:0]  entry_dig [DIGITS];
  logic [DIGIT_W-1:0]  tgt_dig   [DIGITS];
  logic                entry_ok;
  logic [DIGIT_W-1:0]  cur_dig;
  logic                is_bull;
  logic                is_cow;

  assign rise = confirma & ~conf_prev_q;

  // Opponent is the next player in turn order; its secret is the scoring target.
  always_comb begin
    opp    = (player_q == LastPlayer) ? '0 : player_q + PW'(1);
    target = secret_q[opp];
  end

  // Split the entry and target words into digit arrays.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      entry_dig[i] = entry_q[i*DIGIT_W +: DIGIT_W];
      tgt_dig[i]   = target[i*DIGIT_W +: DIGIT_W];
    end
  end

  // An entry is valid when every digit is in range and all digits differ.
  always_comb begin
    entry_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ({1'b0, entry_dig[i]} >= BaseLim) entry_ok = 1'b0;
      for (int j = i + 1; j < DIGITS; j++) begin
        if (entry_dig[i] == entry_dig[j]) entry_ok = 1'b0;
      end
    end
  end

  // Classify the guess digit at idx against the target: bull, cow or neither.
  always_comb begin
    cur_dig = entry_dig[idx_q];
    is_bull = (cur_dig == tgt_dig[idx_q]);
    is_cow  = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j != int'(idx_q)) && (tgt_dig[j] == cur_dig)) is_cow = 1'b1;
    end
  end

  // Game sequencing: next-state for every register.
  always_comb begin
    state_d        = state_q;
    origin_setup_d = origin_setup_q;
    player_d       = player_q;
    round_d        = round_q;
    bulls_d        = bulls_q;
    cows_d         = cows_q;
    rv_d           = 1'b0;
    err_d          = 1'b0;
    winner_d       = winner_q;
    idx_d          = idx_q;
    entry_d        = entry_q;
    secret_d       = secret_q;

    case (state_q)
      StSetup: begin
        if (rise) begin
          entry_d        = SW;
          origin_setup_d = 1'b1;
          state_d        = StValidate;
        end
      end

      StGuess: begin
        if (rise) begin
          entry_d        = SW;
          origin_setup_d = 1'b0;
          state_d        = StValidate;
        end
      end

      StValidate: begin
        if (!entry_ok) begin
          err_d   = 1'b1;
          state_d = origin_setup_q ? StSetup : StGuess;
        end else if (origin_setup_q) begin
          secret_d[player_q] = entry_q;
          if (player_q == LastPlayer) begin
            player_d = '0;
            state_d  = StGuess;
          end else begin
            player_d = player_q + PW'(1);
            state_d  = StSetup;
          end
        end else begin
          bulls_d = '0;
          cows_d  = '0;
          idx_d   = '0;
          state_d = StScore;
        end
      end

      StScore: begin
        // Digits are unique, so a digit is at most one of bull or cow.
        if (is_bull) begin
          bulls_d = bulls_q + CW'(1);
        end else if (is_cow) begin
          cows_d = cows_q + CW'(1);
        end
        if (idx_q == LastIdx) begin
          rv_d    = 1'b1;
          state_d = StResult;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      StResult: begin
        if (rise) begin
          if (bulls_q == AllBulls) begin
            winner_d = player_q;
            state_d  = StWin;
          end else if (player_q == LastPlayer) begin
            player_d = '0;
            round_d  = round_q + RW'(1);
            if ((MAX_ROUNDS != 0) && ((round_q + RW'(1)) == RoundLimit)) begin
              state_d = StDraw;
            end else begin
              state_d = StGuess;
            end
          end else begin
            player_d = player_q + PW'(1);
            state_d  = StGuess;
          end
        end
      end

      StWin, StDraw: begin
        if (rise) begin
          for (int p = 0; p < PLAYERS; p++) secret_d[p] = '0;
          bulls_d  = '0;
          cows_d   = '0;
          round_d  = '0;
          player_d = '0;
          winner_d = '0;
          state_d  = StSetup;
        end
      end

      default: state_d = StSetup;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StSetup;
      origin_setup_q <= 1'b0;
      player_q       <= '0;
      round_q        <= '0;
      bulls_q        <= '0;
      cows_q         <= '0;
      rv_q           <= 1'b0;
      err_q          <= 1'b0;
      winner_q       <= '0;
      idx_q          <= '0;
      entry_q        <= '0;
      conf_prev_q    <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) secret_q[p] <= '0;
    end else begin
      state_q        <= state_d;
      origin_setup_q <= origin_setup_d;
      player_q       <= player_d;
      round_q        <= round_d;
      bulls_q        <= bulls_d;
      cows_q         <= cows_d;
      rv_q           <= rv_d;
      err_q          <= err_d;
      winner_q       <= winner_d;
      idx_q          <= idx_d;
      entry_q        <= entry_d;
      conf_prev_q    <= confirma;
      for (int p = 0; p < PLAYERS; p++) secret_q[p] <= secret_d[p];
    end
  end

  assign state        = state_q;
  assign player       = player_q;
  assign round        = round_q;
  assign bulls        = bulls_q;
  assign cows         = cows_q;
  assign result_valid = rv_q;
  assign err          = err_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_bulls_cows_core.sv
// Bench for bulls_cows_core: directed game scenarios, a game-rule model
// compared every cycle, and literal expectations at key points.
module tb_bulls_cows_core;

  localparam int DIGITS     = 4;
  localparam int DIGIT_W    = 4;
  localparam int BASE       = 10;
  localparam int PLAYERS    = 2;
  localparam int MAX_ROUNDS = 2;
  localparam int SWW        = DIGITS * DIGIT_W;
  localparam int PW         = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
  localparam int RW         = (MAX_ROUNDS > 0) ? $clog2(MAX_ROUNDS + 1) : 1;
  localparam int CW         = $clog2(DIGITS + 1);

  localparam int S_SETUP = 0, S_GUESS = 1, S_VALIDATE = 2, S_SCORE = 3;
  localparam int S_RESULT = 4, S_WIN = 5, S_DRAW = 6;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           confirma = 1'b0;
  logic [SWW-1:0] SW = '0;
  logic [2:0]     state;
  logic [PW-1:0]  player;
  logic [RW-1:0]  round;
  logic [CW-1:0]  bulls, cows;
  logic           result_valid, err;
  logic [PW-1:0]  winner;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  bulls_cows_core #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .BASE(BASE),
    .PLAYERS(PLAYERS), .MAX_ROUNDS(MAX_ROUNDS)
  ) dut (
    .clock(clock), .reset(reset), .confirma(confirma), .SW(SW),
    .state(state), .player(player), .round(round), .bulls(bulls), .cows(cows),
    .result_valid(result_valid), .err(err), .winner(winner)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---- Game-rule model ----
  function automatic bit entry_ok(input logic [SWW-1:0] e);
    bit [(1<<DIGIT_W)-1:0] seen;
    int d;
    seen = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(e[i*DIGIT_W +: DIGIT_W]);
      if (d >= BASE || seen[d]) return 1'b0;
      seen[d] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic score(input logic [SWW-1:0] g, input logic [SWW-1:0] t,
                       output int b, output int c);
    b = 0;
    c = 0;
    for (int i = 0; i < DIGITS; i++)
      for (int j = 0; j < DIGITS; j++)
        if (g[i*DIGIT_W +: DIGIT_W] == t[j*DIGIT_W +: DIGIT_W]) begin
          if (i == j) b++;
          else c++;
        end
  endtask

  int m_state, m_origin, m_player, m_round, m_winner, m_bulls, m_cows;
  int m_cnt, p_bulls, p_cows;
  bit m_rv, m_err, m_chk, m_prev, m_rise;
  logic [SWW-1:0] m_entry;
  logic [SWW-1:0] m_secret [PLAYERS];

  initial begin : model
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_state = S_SETUP; m_origin = S_SETUP; m_player = 0; m_round = 0;
        m_winner = 0; m_bulls = 0; m_cows = 0; m_cnt = 0;
        m_rv = 0; m_err = 0; m_chk = 1; m_prev = 0; m_entry = '0;
        for (int p = 0; p < PLAYERS; p++) m_secret[p] = '0;
      end else begin
        m_rise = confirma && !m_prev;
        m_prev = confirma;
        m_rv = 0;
        m_err = 0;
        case (m_state)
          S_SETUP, S_GUESS: if (m_rise) begin
            m_entry = SW; m_origin = m_state; m_state = S_VALIDATE;
          end
          S_VALIDATE: begin
            if (!entry_ok(m_entry)) begin
              m_err = 1; m_state = m_origin;
            end else if (m_origin == S_SETUP) begin
              m_secret[m_player] = m_entry;
              if (m_player == PLAYERS - 1) begin m_player = 0; m_state = S_GUESS; end
              else begin m_player++; m_state = S_SETUP; end
            end else begin
              score(m_entry, m_secret[(m_player + 1) % PLAYERS], p_bulls, p_cows);
              m_cnt = DIGITS; m_chk = 0; m_state = S_SCORE;
            end
          end
          S_SCORE: begin
            m_cnt--;
            if (m_cnt == 0) begin
              m_bulls = p_bulls; m_cows = p_cows; m_chk = 1; m_rv = 1; m_state = S_RESULT;
            end
          end
          S_RESULT: if (m_rise) begin
            if (m_bulls == DIGITS) begin
              m_winner = m_player; m_state = S_WIN;
            end else if (m_player == PLAYERS - 1) begin
              m_player = 0; m_round++;
              m_state = (MAX_ROUNDS != 0 && m_round == MAX_ROUNDS) ? S_DRAW : S_GUESS;
            end else begin
              m_player++; m_state = S_GUESS;
            end
          end
          default: if (m_rise) begin
            for (int p = 0; p < PLAYERS; p++) m_secret[p] = '0;
            m_bulls = 0; m_cows = 0; m_round = 0; m_player = 0; m_winner = 0;
            m_state = S_SETUP;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model (reset values while reset is low).
  always @(negedge clock) begin
    if (chk_en) begin
      if (!reset) begin
        check("rst_state", int'(state), 0);
        check("rst_player", int'(player), 0);
        check("rst_round", int'(round), 0);
        check("rst_bulls", int'(bulls), 0);
        check("rst_cows", int'(cows), 0);
        check("rst_rv", int'(result_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_winner", int'(winner), 0);
      end else begin
        check("m_state", int'(state), m_state);
        check("m_player", int'(player), m_player);
        check("m_round", int'(round), m_round);
        check("m_rv", int'(result_valid), int'(m_rv));
        check("m_err", int'(err), int'(m_err));
        check("m_winner", int'(winner), m_winner);
        if (m_chk) begin
          check("m_bulls", int'(bulls), m_bulls);
          check("m_cows", int'(cows), m_cows);
        end
      end
    end
  end

  // ---- Stimulus helpers ----
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle press; returns just after the negedge following the sampling edge.
  task automatic pulse(input logic [SWW-1:0] v);
    @(negedge clock); #1; SW = v; confirma = 1'b1;
    @(negedge clock); #1; confirma = 1'b0;
  endtask

  task automatic hold(input logic [SWW-1:0] v, input int n);
    @(negedge clock); #1; SW = v; confirma = 1'b1;
    repeat (n) @(negedge clock);
    #1; confirma = 1'b0;
  endtask

  task automatic guess(input logic [SWW-1:0] v, input int eb, input int ec, input string tag);
    int lat;
    pulse(v);
    check({tag, "_validate"}, int'(state), S_VALIDATE);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (lat < 30 && result_valid !== 1'b1);
    check({tag, "_latency"}, lat, DIGITS + 1);
    check({tag, "_bulls"}, int'(bulls), eb);
    check({tag, "_cows"}, int'(cows), ec);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    #2 reset = 1'b0;
    chk_en = 1'b1;
    tick(3);
    check("reset_state", int'(state), S_SETUP);
    #1 reset = 1'b1;

    // Setup rejection: repeated digit
    pulse(16'h1123);
    check("rej_validate", int'(state), S_VALIDATE);
    tick(1);
    check("rej_err", int'(err), 1);
    check("rej_state", int'(state), S_SETUP);
    check("rej_player", int'(player), 0);
    tick(1);
    check("rej_err_drop", int'(err), 0);

    // Full setup; first button held for several cycles
    hold(16'h1234, 6);
    tick(2);
    check("hold_state", int'(state), S_SETUP);
    check("hold_player", int'(player), 1);
    pulse(16'h5678);
    tick(1);
    check("setup_state", int'(state), S_GUESS);
    check("setup_player", int'(player), 0);

    // P0 scores against P1's secret, then P1 wins
    guess(16'h5687, 2, 2, "g0");
    pulse(16'h0);
    check("g0_next_player", int'(player), 1);
    check("g0_next_state", int'(state), S_GUESS);
    guess(16'h1234, 4, 0, "g1");
    pulse(16'h0);
    check("win_state", int'(state), S_WIN);
    check("win_winner", int'(winner), 1);
    pulse(16'h0);
    check("clr_state", int'(state), S_SETUP);
    check("clr_winner", int'(winner), 0);
    check("clr_bulls", int'(bulls), 0);
    check("clr_cows", int'(cows), 0);

    // Draw after two full rounds, with an out-of-range guess rejected
    pulse(16'h1234); tick(2);
    pulse(16'h5678); tick(2);
    guess(16'h9012, 0, 0, "d0");
    pulse(16'h0);
    guess(16'h4321, 0, 4, "d1");
    pulse(16'h0);
    check("d_round1", int'(round), 1);
    check("d_state1", int'(state), S_GUESS);
    pulse(16'h12A4);
    tick(1);
    check("range_err", int'(err), 1);
    check("range_state", int'(state), S_GUESS);
    guess(16'h5679, 3, 0, "d2");
    pulse(16'h0);
    guess(16'h1243, 2, 2, "d3");
    pulse(16'h0);
    check("draw_state", int'(state), S_DRAW);
    check("draw_round", int'(round), 2);
    pulse(16'h0);
    check("draw_exit", int'(state), S_SETUP);
    check("draw_exit_round", int'(round), 0);

    // Reset in the middle of SCORE
    pulse(16'h1234); tick(2);
    pulse(16'h5678); tick(2);
    pulse(16'h5678);
    tick(2);
    check("mid_score_state", int'(state), S_SCORE);
    #1 reset = 1'b0;
    @(negedge clock);
    check("mid_rst_state", int'(state), S_SETUP);
    check("mid_rst_bulls", int'(bulls), 0);
    check("mid_rst_rv", int'(result_valid), 0);
    #1 reset = 1'b1;
    tick(1);
    pulse(16'h4567);
    check("post_rst_validate", int'(state), S_VALIDATE);
    tick(1);
    check("post_rst_state", int'(state), S_SETUP);
    check("post_rst_player", int'(player), 1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bulls_cows_core.md
# bulls_cows_core

Parametrised Bulls-and-Cows game engine for the Nexys-A7 top level. It generalises the original 2-player, 4-digit game to N players, D digits and a configurable digit base. It adds a round limit with a draw outcome and an explicit invalid-entry error. It scores every guess against the correct opponent's secret, one digit per clock. Display encoding is out of scope: the block exports state, player, bulls and cows, and a separate 7-segment driver consumes them.

## Interface
- DIGITS, default 4: digits per secret/guess (2..8).
- DIGIT_W, default 4: bits per digit.
- BASE, default 10: a digit value must be < BASE (BASE ≤ 2^DIGIT_W).
- PLAYERS, default 2: number of players (2..4).
- MAX_ROUNDS, default 10: full rounds before a draw; 0 means unlimited.
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- confirma  in  1  confirm button; already debounced and synchronous to clock.
- SW  in  DIGITS*DIGIT_W  entry value; digit i is SW[i*DIGIT_W +: DIGIT_W], and digit DIGITS-1 is the leftmost.
- state  out  3  SETUP=0, GUESS=1, VALIDATE=2, SCORE=3, RESULT=4, WIN=5, DRAW=6.
- player  out  max(1,$clog2(PLAYERS))  active player index.
- round  out  $clog2(MAX_ROUNDS+1) (min 1)  completed full rounds.
- bulls, cows  out  $clog2(DIGITS+1) each  score of the last guess.
- result_valid  out  1  one-cycle pulse on entry to RESULT.
- err  out  1  one-cycle pulse when an entry is rejected.
- winner  out  width of player  index of the winning player; valid while in WIN.

## Operation
- Edge detect: the block registers confirma_prev. A rise is confirma=1 with confirma_prev=0. Holding the button produces exactly one rise.
- SETUP: on rise, latch SW into an entry register. Go to VALIDATE with origin=SETUP.
- GUESS: on rise, latch SW into the entry register. Go to VALIDATE with origin=GUESS.
- VALIDATE (1 cycle): an entry is valid when all digits are pairwise distinct and every digit is < BASE.
  - Invalid: pulse err and return to origin. Player, round and the secrets are unchanged.
  - Valid with origin SETUP: write the entry to secret[player]. If player < PLAYERS-1, player++ and go to SETUP. Otherwise player=0 and go to GUESS.
  - Valid with origin GUESS: clear bulls and cows, set idx=0, go to SCORE.
- SCORE (DIGITS cycles): the target is secret[(player+1) mod PLAYERS]. Each cycle handles digit idx:
  - If guess[idx] == target[idx], bulls++.
  - Else if guess[idx] matches any other target digit, cows++.
  - After idx=DIGITS-1, go to RESULT.
  - Digits are unique, so there is no double counting and bulls+cows ≤ DIGITS.
- RESULT: pulse result_valid on the entry cycle. Hold bulls and cows. On rise:
  - If bulls == DIGITS: winner=player, go to WIN.
  - Else if player == PLAYERS-1: player=0 and round++. If MAX_ROUNDS≠0 and the new round == MAX_ROUNDS, go to DRAW. Otherwise go to GUESS.
  - Else player++ and go to GUESS.
- WIN / DRAW: on rise, clear the secrets, bulls, cows, round, player and winner, then go to SETUP.
- Undefined state encodings return to SETUP on the next edge.

## Timing
- Reset (asynchronous assert, synchronous release) sets state=SETUP. Player, round, bulls, cows, winner, err, result_valid, the secrets and confirma_prev all reset to 0.
- If confirma is sampled high at edge N (after sampling low), the state leaves SETUP/GUESS/RESULT/WIN/DRAW at edge N.
- Guess-to-result latency: VALIDATE takes 1 cycle and SCORE takes DIGITS cycles. result_valid is therefore high in the cycle after edge N+1+DIGITS.
- Rises during VALIDATE or SCORE are ignored, not queued.
- The err pulse is high for the single cycle after VALIDATE.
- Reset mid-SCORE discards the partial counts. There are no outputs from the aborted guess.
- Outputs are registered. bulls and cows change only during SCORE and on the WIN/DRAW exit.

## Test plan
- Setup rejection: P0 enters 0x1123, then confirm. Required: err pulse, state back to SETUP, player=0, secret not written.
- Full setup: P0=0x1234, P1=0x5678, each with one press. Required: state=GUESS, player=0. A held button produces no extra advance.
- Scoring uses the opponent's secret: P0 guesses 0x5687. Required: result_valid exactly 1+DIGITS cycles after the VALIDATE edge, bulls=2, cows=2.
- Win: P0 misses, then P1 guesses 0x1234. Required: state=WIN, winner=1. The next press gives state=SETUP with all outputs 0.
- Draw: MAX_ROUNDS=2, four non-winning guesses. Required: round=2, state=DRAW.
- Reset mid-SCORE: assert reset during SCORE. Required: all outputs at reset values on the next cycle, and the next confirm is accepted in SETUP.
